// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes mult/div results at launch
// and commits them after a fixed busy window so the hazard unit sees a constant latency.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      hi_d, lo_d;

    logic [63:0] prod_s, prod_u;
    logic        div_zero;
    logic [31:0] divisor, a_mag, b_mag, q_mag, r_mag;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    // Products: the low 64 bits of a sign-extended product equal the signed result.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly; zero divisor is masked.
    assign div_zero = (rt_val == 32'd0);
    assign divisor  = div_zero ? 32'd1 : rt_val;
    assign a_mag    = rs_val[31] ? -rs_val : rs_val;
    assign b_mag    = divisor[31] ? -divisor : divisor;
    assign q_mag    = a_mag / b_mag;
    assign r_mag    = a_mag % b_mag;
    assign quot_s   = (rs_val[31] ^ divisor[31]) ? -q_mag : q_mag;
    assign rem_s    = rs_val[31] ? -r_mag : r_mag;
    assign quot_u   = rs_val / divisor;
    assign rem_u    = rs_val % divisor;

    always_comb begin
        cnt_d        = cnt_q;
        busy_d       = busy;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_valid_d = pend_valid_q;
        hi_d         = hi;
        lo_d         = lo;

        if (busy) begin
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q != CNT_W'(1));
            if ((cnt_q == CNT_W'(1)) && pend_valid_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else begin
            // Launches need start; mthi/mtlo only need an idle unit.
            case (md_op)
                OP_MULT: if (start) begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    pend_valid_d           = 1'b1;
                    cnt_d                  = CNT_W'(MULT_CYCLES);
                    busy_d                 = 1'b1;
                end
                OP_MULTU: if (start) begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    pend_valid_d           = 1'b1;
                    cnt_d                  = CNT_W'(MULT_CYCLES);
                    busy_d                 = 1'b1;
                end
                OP_DIV: if (start) begin
                    pend_hi_d    = rem_s;
                    pend_lo_d    = quot_s;
                    pend_valid_d = !div_zero;
                    cnt_d        = CNT_W'(DIV_CYCLES);
                    busy_d       = 1'b1;
                end
                OP_DIVU: if (start) begin
                    pend_hi_d    = rem_u;
                    pend_lo_d    = quot_u;
                    pend_valid_d = !div_zero;
                    cnt_d        = CNT_W'(DIV_CYCLES);
                    busy_d       = 1'b1;
                end
                OP_MTHI: hi_d = rs_val;
                OP_MTLO: lo_d = rs_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            busy         <= 1'b0;
            pend_hi_q    <= 32'd0;
            pend_lo_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            hi           <= 32'd0;
            lo           <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            busy         <= busy_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            pend_valid_q <= pend_valid_d;
            hi           <= hi_d;
            lo           <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops, with commits checked
// by a monitor against a scoreboard fed from an arithmetic reference model.
module tb_mult_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic [2:0]  md_op  = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result from plain integer arithmetic; divide by zero leaves HI/LO.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] old_hi, input logic [31:0] old_lo,
                                  output logic [31:0] new_hi, output logic [31:0] new_lo);
        int          sa, sb;
        longint      p, q, r;
        logic [63:0] pu;
        sa     = a;
        sb     = b;
        new_hi = old_hi;
        new_lo = old_lo;
        case (op)
            3'd1: begin
                p      = longint'(sa) * longint'(sb);
                new_hi = p[63:32];
                new_lo = p[31:0];
            end
            3'd2: begin
                pu     = {32'd0, a} * {32'd0, b};
                new_hi = pu[63:32];
                new_lo = pu[31:0];
            end
            3'd3: if (b != 32'd0) begin
                q      = longint'(sa) / longint'(sb);
                r      = longint'(sa) % longint'(sb);
                new_hi = r[31:0];
                new_lo = q[31:0];
            end
            3'd4: if (b != 32'd0) begin
                new_hi = a % b;
                new_lo = a / b;
            end
            default: ;
        endcase
    endfunction

    // Monitor: a falling busy marks a commit; pop and compare against the scoreboard.
    int   busy_cnt  = 0;
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset) begin
            sb_q.delete();
            busy_prev = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
            end else if (busy_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("commit_hi", hi, e.hi);
                    check("commit_lo", lo, e.lo);
                    check("commit_busy_cycles", 32'(busy_cnt), 32'(e.cycles));
                end
                busy_cnt = 0;
            end
            busy_prev = busy;
        end
    end

    // Entered and left at a negedge; inject 1 = DIV start, 2 = MTLO on the second busy cycle.
    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [31:0] eh, el;
        exp_t        e;
        int          k;
        model(op, a, b, m_hi, m_lo, eh, el);
        e.hi     = eh;
        e.lo     = el;
        e.cycles = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
        sb_q.push_back(e);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1 check("busy_not_comb", 32'(busy), 32'd0);
        @(negedge clk);
        start  = 1'b0;
        md_op  = 3'd0;
        rs_val = $urandom;
        rt_val = $urandom;
        k = 0;
        while (busy && k < 40) begin
            k++;
            check("hold_hi", hi, m_hi);
            check("hold_lo", lo, m_lo);
            if (k == 2 && inject == 1) begin
                start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
            end else if (k == 2 && inject == 2) begin
                md_op = 3'd6; rs_val = 32'h0000ABCD;
            end else if (k == 3) begin
                start = 1'b0; md_op = 3'd0;
            end
            @(negedge clk);
        end
        if (k >= 40) check("busy_timeout", 32'd1, 32'd0);
        check("busy_len", 32'(k), 32'(e.cycles));
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] v);
        start  = 1'($urandom_range(0, 1));
        md_op  = op;
        rs_val = v;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        if (op == 3'd5) m_hi = v; else m_lo = v;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
        check("mt_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_ignored(input logic [2:0] op);
        start  = 1'b1;
        md_op  = op;
        rs_val = $urandom;
        rt_val = $urandom;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        check("ign_busy", 32'(busy), 32'd0);
        check("ign_hi", hi, m_hi);
        check("ign_lo", lo, m_lo);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        int          sel;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reset two cycles into a MULT must discard the product.
        do_mt(3'd5, 32'h55);
        do_mt(3'd6, 32'h66);
        start = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (8) begin
            @(negedge clk);
            check("post_reset_busy", 32'(busy), 32'd0);
            check("post_reset_hi", hi, 32'd0);
            check("post_reset_lo", lo, 32'd0);
        end

        do_md(3'd1, 32'hFFFFFFFF, 32'd2, 0);
        do_md(3'd2, 32'hFFFFFFFF, 32'd2, 0);
        do_md(3'd3, 32'hFFFFFFF9, 32'd2, 0);
        do_md(3'd4, 32'd7, 32'd2, 0);
        do_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);

        do_mt(3'd5, 32'h1111);
        do_mt(3'd6, 32'h2222);
        do_md(3'd4, 32'h1234, 32'd0, 0);
        check("div0_hi", hi, 32'h1111);
        check("div0_lo", lo, 32'h2222);

        do_md(3'd1, 32'h00012345, 32'h00006789, 1);
        do_md(3'd1, 32'hFFFF0001, 32'h00030000, 2);
        do_mt(3'd6, 32'h0000ABCD);

        do_md(3'd3, 32'd100, 32'd7, 0);
        do_md(3'd1, 32'd9, 32'hFFFFFFF7, 0);

        do_ignored(3'd0);
        do_ignored(3'd7);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            if (sel < 8)       do_md(3'(1 + (sel % 4)), a, b, 0);
            else if (sel == 8) do_mt(3'd5, a);
            else               do_mt(3'd6, a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
